// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, pipelined ibus requests, in-order prefetch FIFO.
// Optional perf counters enabled by IF_FETCH_PERF_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        stall_n,
    input  logic        hold_flag,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_err,
    output logic [31:0] instruction_addr_if,
    output logic [31:0] instruction_if,
    output logic        exception_if,
    output logic        inst_valid_if
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t state, state_nx;

    logic [31:0] pc;
    logic [31:0] resp_pc;
    logic [31:0] last_addr;
    logic [CW-1:0] outstanding, out_nx;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] head, tail;
    logic [CW:0] occupancy;

    logic [31:0] fifo_addr [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic        fifo_err  [FIFO_DEPTH];

    logic empty, misalign, grant, drop, keep, pop;

    assign empty     = (count == '0);
    assign misalign  = jump_flag && (jump_addr[1:0] != 2'b00);
    assign grant     = ibus_req && ibus_gnt;
    assign drop      = ibus_rvalid && (discard != '0);
    assign keep      = ibus_rvalid && (discard == '0) && !jump_flag;
    assign pop       = stall_n && !hold_flag && !empty && !jump_flag;
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign out_nx    = outstanding + CW'(grant) - CW'(ibus_rvalid);

    // Occupancy never grows while a request waits, so req stays stable.
    assign ibus_req  = (state == S_RUN) && (occupancy < DEPTH_V);
    assign ibus_addr = pc;

    always_ff @(posedge clk) begin
        if (rst_sync) state <= S_BOOT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_BOOT: state_nx = S_RUN;
            S_RUN:  if (keep && ibus_err) state_nx = S_HALT;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_BOOT;
        endcase
        if (jump_flag) state_nx = misalign ? S_HALT : S_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            pc          <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            last_addr   <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            outstanding <= out_nx;
            if (grant) pc <= pc + 32'd4;
            if (!empty) last_addr <= fifo_addr[head];
            if (jump_flag) begin
                // Everything still in flight after this edge belongs to the old path.
                pc      <= jump_addr;
                resp_pc <= jump_addr;
                discard <= out_nx;
                head    <= '0;
                if (misalign) begin
                    fifo_addr[0] <= jump_addr;
                    fifo_data[0] <= INST_NOP;
                    fifo_err[0]  <= 1'b1;
                    tail         <= PW'(1);
                    count        <= CW'(1);
                end else begin
                    tail  <= '0;
                    count <= '0;
                end
            end else begin
                if (drop) discard <= discard - CW'(1);
                if (keep) begin
                    fifo_addr[tail] <= resp_pc;
                    fifo_data[tail] <= ibus_rdata;
                    fifo_err[tail]  <= ibus_err;
                    tail            <= tail + PW'(1);
                    resp_pc         <= resp_pc + 32'd4;
                end
                if (pop) head <= head + PW'(1);
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_comb begin
        inst_valid_if       = !empty;
        exception_if        = 1'b0;
        instruction_if      = INST_NOP;
        instruction_addr_if = last_addr;
        if (!empty) begin
            instruction_addr_if = fifo_addr[head];
            exception_if        = fifo_err[head];
            if (!fifo_err[head]) instruction_if = fifo_data[head];
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            perf_fetch_cnt  <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (grant) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_n && empty && (state != S_HALT))
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with an in-order ibus responder.
// Perf outputs are connected when IF_FETCH_PERF_EN is defined.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        stall_n;
    logic        hold_flag;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        ibus_err;
    logic [31:0] instruction_addr_if;
    logic [31:0] instruction_if;
    logic        exception_if;
    logic        inst_valid_if;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int grants = 0;
    logic        resp_en;
    logic [31:0] err_addr;
    logic [31:0] pend [$];

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk                 (clk),
        .rst_sync            (rst_sync),
        .stall_n             (stall_n),
        .hold_flag           (hold_flag),
        .jump_flag           (jump_flag),
        .jump_addr           (jump_addr),
        .ibus_req            (ibus_req),
        .ibus_addr           (ibus_addr),
        .ibus_gnt            (ibus_gnt),
        .ibus_rvalid         (ibus_rvalid),
        .ibus_rdata          (ibus_rdata),
        .ibus_err            (ibus_err),
        .instruction_addr_if (instruction_addr_if),
        .instruction_if      (instruction_if),
        .exception_if        (exception_if),
        .inst_valid_if       (inst_valid_if)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt      (perf_fetch_cnt),
        .perf_starve_cnt     (perf_starve_cnt)
`endif
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'h0010_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the responder answers one cycle after a grant.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        @(negedge clk);
        g  = ibus_req && ibus_gnt;
        ga = ibus_addr;
        @(posedge clk);
        #1;
        if (rst_sync) begin
            pend.delete();
            grants = 0;
            ibus_rvalid = 1'b0;
        end else begin
            if (g) begin
                pend.push_back(ga);
                grants++;
            end
            ibus_rvalid = 1'b0;
            ibus_err    = 1'b0;
            if (resp_en && pend.size() > 0) begin
                ibus_rvalid = 1'b1;
                ibus_rdata  = mem(pend[0]);
                ibus_err    = (pend[0] == err_addr);
                void'(pend.pop_front());
            end
        end
    endtask

    initial begin
        rst_sync = 1'b1;
        stall_n = 1'b1;
        hold_flag = 1'b0;
        jump_flag = 1'b0;
        jump_addr = '0;
        ibus_gnt = 1'b1;
        ibus_rvalid = 1'b0;
        ibus_rdata = '0;
        ibus_err = 1'b0;
        resp_en = 1'b1;
        err_addr = 32'h108;

        tick();
        tick();
        chk("rst_req", 32'(ibus_req), 32'd0);
        chk("rst_valid", 32'(inst_valid_if), 32'd0);
        chk("rst_exc", 32'(exception_if), 32'd0);
        chk("rst_inst", instruction_if, NOP);
        chk("rst_addr", instruction_addr_if, 32'h0);
        rst_sync = 1'b0;

        // C0: boot cycle
        chk("boot_req", 32'(ibus_req), 32'd0);
        tick(); // C1
        chk("c1_req", 32'(ibus_req), 32'd1);
        chk("c1_addr", ibus_addr, 32'h0);
        tick(); // C2
        chk("c2_addr", ibus_addr, 32'h4);
        chk("c2_valid", 32'(inst_valid_if), 32'd0);
        tick(); // C3
        chk("c3_valid", 32'(inst_valid_if), 32'd1);
        chk("c3_iaddr", instruction_addr_if, 32'h0);
        chk("c3_inst", instruction_if, 32'h0010_0093);
        chk("c3_req", 32'(ibus_req), 32'd0);
        tick(); // C4
        chk("c4_iaddr", instruction_addr_if, 32'h4);
        chk("c4_addr", ibus_addr, 32'h8);
        stall_n = 1'b0;

        tick();
        tick();
        tick();
        tick(); // C8
        chk("stall_req", 32'(ibus_req), 32'd0);
        chk("stall_iaddr", instruction_addr_if, 32'h4);
        chk("stall_valid", 32'(inst_valid_if), 32'd1);
        tick(); // C9
        stall_n = 1'b1;
        tick(); // C10
        chk("c10_iaddr", instruction_addr_if, 32'h8);
        chk("c10_inst", instruction_if, 32'h0010_009b);
        chk("c10_addr", ibus_addr, 32'hc);
        resp_en = 1'b0;

        tick(); // C11
        chk("c11_addr", ibus_addr, 32'h10);
        tick(); // C12
        chk("c12_req", 32'(ibus_req), 32'd0);
        jump_flag = 1'b1;
        jump_addr = 32'h100;
        resp_en = 1'b1;
        tick(); // C13
        jump_flag = 1'b0;
        chk("c13_valid", 32'(inst_valid_if), 32'd0);
        chk("c13_req", 32'(ibus_req), 32'd0);
        chk("c13_hold_addr", instruction_addr_if, 32'h8);
        chk("c13_inst", instruction_if, NOP);
        tick(); // C14
        chk("c14_addr", ibus_addr, 32'h100);
        chk("c14_valid", 32'(inst_valid_if), 32'd0);
        tick(); // C15
        chk("c15_valid", 32'(inst_valid_if), 32'd0);
        chk("c15_addr", ibus_addr, 32'h104);
        tick(); // C16
        chk("c16_iaddr", instruction_addr_if, 32'h100);
        chk("c16_inst", instruction_if, 32'h0010_0193);

        tick();
        tick();
        tick(); // C19
        chk("err_exc", 32'(exception_if), 32'd1);
        chk("err_inst", instruction_if, NOP);
        chk("err_iaddr", instruction_addr_if, 32'h108);
        chk("err_req", 32'(ibus_req), 32'd0);
        stall_n = 1'b0;
        tick(); // C20
        chk("halt_req", 32'(ibus_req), 32'd0);
        chk("halt_exc", 32'(exception_if), 32'd1);
        jump_flag = 1'b1;
        jump_addr = 32'h200;
        stall_n = 1'b1;
        tick(); // C21
        chk("j200_req", 32'(ibus_req), 32'd1);
        chk("j200_addr", ibus_addr, 32'h200);
        jump_addr = 32'h102;
        err_addr = 32'hffff_ffff;

        tick(); // C22
        jump_flag = 1'b0;
        chk("mis_exc", 32'(exception_if), 32'd1);
        chk("mis_iaddr", instruction_addr_if, 32'h102);
        chk("mis_inst", instruction_if, NOP);
        chk("mis_req", 32'(ibus_req), 32'd0);
        tick(); // C23
        chk("mis_empty", 32'(inst_valid_if), 32'd0);
        chk("mis_held", instruction_addr_if, 32'h102);
        chk("mis_req2", 32'(ibus_req), 32'd0);
        jump_flag = 1'b1;
        jump_addr = 32'h104;
        tick(); // C24
        jump_flag = 1'b0;
        chk("j104_addr", ibus_addr, 32'h104);
        chk("j104_req", 32'(ibus_req), 32'd1);
        tick(); // C25
        chk("c25_addr", ibus_addr, 32'h108);
        tick(); // C26
        chk("c26_iaddr", instruction_addr_if, 32'h104);
        chk("c26_inst", instruction_if, 32'h0010_0197);
        hold_flag = 1'b1;
        tick(); // C27
        chk("hold_iaddr", instruction_addr_if, 32'h104);
        chk("hold_valid", 32'(inst_valid_if), 32'd1);
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'(grants));
`endif
        hold_flag = 1'b0;
        rst_sync = 1'b1;
        tick(); // mid-transfer reset
        chk("mrst_valid", 32'(inst_valid_if), 32'd0);
        chk("mrst_req", 32'(ibus_req), 32'd0);
        chk("mrst_addr", instruction_addr_if, 32'h0);
        rst_sync = 1'b0;
        tick();
        chk("mrst_fetch", 32'(ibus_req), 32'd1);
        chk("mrst_faddr", ibus_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
